// File: rtl/branch_if.sv
// Branch controller bus: decoded-branch request in, fetch-redirect target out,
// plus the flush, link-register write and not-taken side signals.
interface branch_if;
  // Handshakes: a request transfers on a rising edge where instr_valid and
  // instr_ready are both 1; a target transfers on a rising edge where
  // target_valid and target_ack are both 1. A valid holds its payload stable
  // until that edge and never waits on its ready/ack.
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  cond;
  logic        link;
  logic [23:0] imm24;
  logic [31:0] pc;
  logic [3:0]  flags;
  logic        target_valid;
  logic [31:0] target_addr;
  logic        target_ack;
  logic        flush;
  logic        lr_we;
  logic [31:0] lr_data;
  logic        not_taken;

  modport master (
    output instr_valid, cond, link, imm24, pc, flags, target_ack,
    input  instr_ready, target_valid, target_addr, flush, lr_we, lr_data, not_taken
  );

  modport slave (
    input  instr_valid, cond, link, imm24, pc, flags, target_ack,
    output instr_ready, target_valid, target_addr, flush, lr_we, lr_data, not_taken
  );
endinterface

// File: rtl/branch_ctrl.sv
// ARM-style branch controller: evaluates the condition, sign-extends and scales
// the word offset, issues the target to fetch, then holds a pipeline flush.
module branch_ctrl #(
    parameter int FLUSH_CYCLES = 2  // legal 1..15
) (
    input  logic       clk,
    input  logic       rst,
    branch_if.slave    bus,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EXTEND = 3'd1,
        CALC   = 3'd2,
        ISSUE  = 3'd3,
        FLUSH  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        link_q, link_d;
    logic [23:0] imm_q, imm_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ext_q, ext_d;
    logic [31:0] target_addr_q, target_addr_d;
    logic [31:0] lr_data_q, lr_data_d;
    logic        target_valid_q, target_valid_d;
    logic        flush_q, flush_d;
    logic        lr_we_q, lr_we_d;
    logic        not_taken_q, not_taken_d;
    logic        instr_ready_q, instr_ready_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic        cond_pass;

    always_comb begin
        logic n, z, c, v;
        n = bus.flags[3];
        z = bus.flags[2];
        c = bus.flags[1];
        v = bus.flags[0];
        cond_pass = 1'b0;
        case (bus.cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c & !z;
            4'b1001: cond_pass = !c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        link_d         = link_q;
        imm_d          = imm_q;
        pc_d           = pc_q;
        ext_d          = ext_q;
        target_addr_d  = target_addr_q;
        lr_data_d      = lr_data_q;
        target_valid_d = target_valid_q;
        flush_d        = flush_q;
        lr_we_d        = 1'b0;
        not_taken_d    = 1'b0;
        instr_ready_d  = instr_ready_q;
        flush_cnt_d    = flush_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    link_d = bus.link;
                    imm_d  = bus.imm24;
                    pc_d   = bus.pc;
                    if (cond_pass) begin
                        state_d       = EXTEND;
                        instr_ready_d = 1'b0;
                    end else begin
                        not_taken_d = 1'b1;
                    end
                end
            end
            EXTEND: begin
                ext_d   = {{8{imm_q[23]}}, imm_q};
                state_d = CALC;
            end
            CALC: begin
                // ARM PC reads two instructions ahead, hence the +8.
                target_addr_d  = pc_q + 32'd8 + {ext_q[29:0], 2'b00};
                lr_data_d      = pc_q + 32'd4;
                target_valid_d = 1'b1;
                state_d        = ISSUE;
            end
            ISSUE: begin
                if (bus.target_ack) begin
                    target_valid_d = 1'b0;
                    flush_d        = 1'b1;
                    lr_we_d        = link_q;
                    flush_cnt_d    = 4'(FLUSH_CYCLES - 1);
                    state_d        = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == 4'd0) begin
                    flush_d       = 1'b0;
                    instr_ready_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d        = IDLE;
                instr_ready_d  = 1'b1;
                target_valid_d = 1'b0;
                flush_d        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            link_q         <= 1'b0;
            imm_q          <= 24'd0;
            pc_q           <= 32'd0;
            ext_q          <= 32'd0;
            target_addr_q  <= 32'd0;
            lr_data_q      <= 32'd0;
            target_valid_q <= 1'b0;
            flush_q        <= 1'b0;
            lr_we_q        <= 1'b0;
            not_taken_q    <= 1'b0;
            instr_ready_q  <= 1'b1;
            flush_cnt_q    <= 4'd0;
        end else begin
            state_q        <= state_d;
            link_q         <= link_d;
            imm_q          <= imm_d;
            pc_q           <= pc_d;
            ext_q          <= ext_d;
            target_addr_q  <= target_addr_d;
            lr_data_q      <= lr_data_d;
            target_valid_q <= target_valid_d;
            flush_q        <= flush_d;
            lr_we_q        <= lr_we_d;
            not_taken_q    <= not_taken_d;
            instr_ready_q  <= instr_ready_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    assign bus.instr_ready  = instr_ready_q;
    assign bus.target_valid = target_valid_q;
    assign bus.target_addr  = target_addr_q;
    assign bus.flush        = flush_q;
    assign bus.lr_we        = lr_we_q;
    assign bus.lr_data      = lr_data_q;
    assign bus.not_taken    = not_taken_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed branch cases plus random branches checked
// against a condition/offset reference model and cycle-level timing.
module tb_branch_ctrl;
  localparam int FLUSH_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;
  int         errors = 0;
  int         checks = 0;
  logic [31:0] exp_q[$];

  branch_if bus();

  branch_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: ARM condition table on named flags.
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: word offset as a signed integer, byte target mod 2^32.
  function automatic logic [31:0] exp_target(input logic [31:0] p, input logic [23:0] imm);
    longint off;
    off = longint'(imm);
    if (imm[23]) off = off - 64'sd16777216;
    return 32'(longint'(p) + 64'sd8 + off * 64'sd4);
  endfunction

  task automatic scramble();
    bus.instr_valid = 1'($urandom_range(0, 1));
    bus.cond        = 4'($urandom);
    bus.link        = 1'($urandom_range(0, 1));
    bus.imm24       = 24'($urandom);
    bus.pc          = $urandom;
    bus.flags       = 4'($urandom);
  endtask

  // Called on a negedge with the DUT idle; returns on a negedge with the DUT idle.
  task automatic run_branch(input logic [3:0] c, input logic l, input logic [23:0] imm,
                            input logic [31:0] p, input logic [3:0] f, input int stall,
                            input bit rst_in_flush);
    bit taken;
    logic [31:0] exp_t;
    taken = cond_holds(c, f);
    check("ready_pre", bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.cond = c; bus.link = l; bus.imm24 = imm; bus.pc = p; bus.flags = f;
    bus.target_ack = 1'b0;
    if (taken) exp_q.push_back(exp_target(p, imm));
    @(posedge clk);
    @(negedge clk);
    check("not_taken_c1", bus.not_taken, 32'(!taken));
    check("ready_c1", bus.instr_ready, 32'(!taken));
    check("tvalid_c1", bus.target_valid, 0);
    check("flush_c1", bus.flush, 0);
    if (!taken) begin
      bus.instr_valid = 1'b0;
      @(negedge clk);
      check("not_taken_c2", bus.not_taken, 0);
      check("tvalid_nt", bus.target_valid, 0);
      check("flush_nt", bus.flush, 0);
      check("lr_we_nt", bus.lr_we, 0);
      return;
    end
    scramble();
    bus.target_ack = 1'b1;
    @(negedge clk);
    check("tvalid_c2", bus.target_valid, 0);
    check("ready_c2", bus.instr_ready, 0);
    scramble();
    bus.target_ack = 1'b0;
    @(negedge clk);
    exp_t = exp_q.pop_front();
    check("tvalid_c3", bus.target_valid, 1);
    check("target_c3", bus.target_addr, exp_t);
    for (int i = 0; i < stall; i++) begin
      scramble();
      @(negedge clk);
      check("tvalid_stall", bus.target_valid, 1);
      check("target_stall", bus.target_addr, exp_t);
      check("ready_stall", bus.instr_ready, 0);
      check("flush_stall", bus.flush, 0);
    end
    scramble();
    bus.target_ack = 1'b1;
    @(negedge clk);
    bus.target_ack = 1'b0;
    check("flush_f0", bus.flush, 1);
    check("tvalid_f0", bus.target_valid, 0);
    check("lr_we_f0", bus.lr_we, 32'(l));
    if (l) check("lr_data", bus.lr_data, p + 32'd4);
    if (rst_in_flush) begin
      bus.instr_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst_flush", bus.flush, 0);
      check("rst_ready", bus.instr_ready, 1);
      check("rst_tvalid", bus.target_valid, 0);
      check("rst_lr_we", bus.lr_we, 0);
      check("rst_state", dbg_state, 0);
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    for (int i = 1; i < FLUSH_CYCLES; i++) begin
      scramble();
      @(negedge clk);
      check("flush_hold", bus.flush, 1);
      check("lr_we_hold", bus.lr_we, 0);
      check("ready_flush", bus.instr_ready, 0);
    end
    scramble();
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("flush_end", bus.flush, 0);
    check("ready_end", bus.instr_ready, 1);
    check("lr_we_end", bus.lr_we, 0);
    check("tvalid_end", bus.target_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.instr_valid = 1'b0; bus.cond = 4'd0; bus.link = 1'b0; bus.imm24 = 24'd0;
    bus.pc = 32'd0; bus.flags = 4'd0; bus.target_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", bus.instr_ready, 1);
    check("reset_tvalid", bus.target_valid, 0);
    check("reset_flush", bus.flush, 0);
    check("reset_lr_we", bus.lr_we, 0);
    check("reset_not_taken", bus.not_taken, 0);
    check("reset_target", bus.target_addr, 0);
    check("reset_lr_data", bus.lr_data, 0);
    check("reset_state", dbg_state, 0);
    rst = 1'b0;

    run_branch(4'hE, 1'b0, 24'h000010, 32'h0000_1000, 4'h0, 0, 1'b0);
    run_branch(4'hE, 1'b1, 24'hFFFFFE, 32'h0000_2000, 4'h0, 1, 1'b0);
    run_branch(4'h0, 1'b0, 24'h000020, 32'h0000_3000, 4'b0000, 0, 1'b0);
    run_branch(4'h0, 1'b0, 24'h000020, 32'h0000_3000, 4'b0100, 0, 1'b0);
    run_branch(4'hE, 1'b1, 24'h000004, 32'hFFFF_FFF0, 4'h0, 2, 1'b0);
    run_branch(4'hF, 1'b1, 24'h000004, 32'h0000_4000, 4'hF, 0, 1'b0);
    run_branch(4'hE, 1'b0, 24'h123456, 32'h0001_0000, 4'h0, 5, 1'b0);
    run_branch(4'hE, 1'b1, 24'h000100, 32'h0000_5000, 4'h0, 0, 1'b1);
    run_branch(4'hE, 1'b1, 24'h800000, 32'h8000_0000, 4'h0, 0, 1'b0);

    for (int k = 0; k < 60; k++) begin
      run_branch(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 24'($urandom),
                 $urandom, 4'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
